fabric_cfg_loader: RTL and testbench

//  Streaming configuration controller for the island-style FPGA fabric (logic boxes, IO, CB, SB).

---
 rtl/fabric_cfg_pkg.sv | 32 +++
 rtl/fabric_cfg_loader_bank.sv | 35 +++
 rtl/fabric_cfg_loader.sv | 113 +++++++++++
 tb/tb_fabric_cfg_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// Shared types and field layout for the fabric configuration loader.
// Offsets slice cfg_active into the per-resource config ports.
package fabric_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK
  } cfg_state_t;

  localparam int CFG_BITS_DEF = 891;

  localparam int BLE_OFF   = 0;
  localparam int BLE_W     = 9;
  localparam int IOSEL_OFF = 9;
  localparam int IOSEL_W   = 4;
  localparam int IO_OFF    = 13;
  localparam int IO_W      = 20;
  localparam int LUT_OFF   = 33;
  localparam int LUT_W     = 144;
  localparam int SB_OFF    = 177;
  localparam int SB_W      = 240;
  localparam int CB_OFF    = 417;
  localparam int CB_W      = 420;
  localparam int DIR_OFF   = 837;
  localparam int DIR_W     = 54;

  function automatic int words_for(input int bits, input int dw);
    return (bits + dw - 1) / dw;
  endfunction

endpackage

// File: rtl/fabric_cfg_loader_bank.sv
// Shadow bank filled word by word, copied to the active bank on commit.
// Only CFG_BITS shadow bits exist; padding in the last word is dropped.
module cfg_shadow_bank
  import fabric_cfg_pkg::*;
#(
  parameter int CFG_BITS = CFG_BITS_DEF,
  parameter int DW       = 8,
  parameter int IW       = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [IW-1:0]       idx,
  input  logic [DW-1:0]       data,
  input  logic                commit,
  output logic [CFG_BITS-1:0] active
);

  logic [CFG_BITS-1:0] shadow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
      active <= '0;
    end else begin
      for (int b = 0; b < CFG_BITS; b++) begin
        if (we && idx == IW'(b / DW))
          shadow[b] <= data[b % DW];
      end
      if (commit)
        active <= shadow;
    end
  end

endmodule

// File: rtl/fabric_cfg_loader.sv
// Streaming config loader: valid/ready words into a shadow bank,
// checksum-verified atomic commit to the active fabric configuration.
module fabric_cfg_loader
  import fabric_cfg_pkg::*;
#(
  parameter  int CFG_BITS = CFG_BITS_DEF,
  parameter  int DW       = 8,
  parameter  int CHECK_EN = 1,
  localparam int W        = words_for(CFG_BITS, DW),
  localparam int CW       = $clog2(W + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_start,
  input  logic                cfg_abort,
  input  logic                cfg_valid,
  input  logic [DW-1:0]       cfg_data,
  output logic                cfg_ready,
  output logic                cfg_busy,
  output logic                cfg_done,
  output logic                cfg_error,
  output logic [CW-1:0]       cfg_count,
  output logic                fabric_en,
  output logic [CFG_BITS-1:0] cfg_active
);

  cfg_state_t    state;
  logic [DW-1:0] sum;
  logic [CW-1:0] count;
  logic          pend_ok;
  logic          pend_bad;
  logic          xfer;
  logic          wr_en;
  logic          last_word;

  assign cfg_ready = (state != IDLE);
  assign cfg_busy  = cfg_ready;
  assign cfg_count = count;
  assign xfer      = cfg_valid & cfg_ready;
  assign last_word = (count == CW'(W - 1));
  assign wr_en     = xfer && state == LOAD
                     && !cfg_start && !cfg_abort;

  // Final transfer latches pend_*; results surface one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sum       <= '0;
      count     <= '0;
      pend_ok   <= 1'b0;
      pend_bad  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
      fabric_en <= 1'b0;
    end else begin
      cfg_done <= pend_ok;
      pend_ok  <= 1'b0;
      pend_bad <= 1'b0;
      if (pend_ok)
        fabric_en <= 1'b1;
      if (pend_bad)
        cfg_error <= 1'b1;
      if (cfg_start) begin
        state     <= LOAD;
        count     <= '0;
        sum       <= '0;
        cfg_error <= 1'b0;
      end else if (state != IDLE) begin
        if (cfg_abort) begin
          state <= IDLE;
        end else if (xfer) begin
          unique case (state)
            LOAD: begin
              sum   <= sum + cfg_data;
              count <= count + 1'b1;
              if (last_word) begin
                if (CHECK_EN != 0) begin
                  state <= CHECK;
                end else begin
                  state   <= IDLE;
                  pend_ok <= 1'b1;
                end
              end
            end
            CHECK: begin
              state <= IDLE;
              if (cfg_data == sum)
                pend_ok <= 1'b1;
              else
                pend_bad <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  cfg_shadow_bank #(
    .CFG_BITS (CFG_BITS),
    .DW       (DW),
    .IW       (CW)
  ) u_bank (
    .clk    (clk),
    .reset  (reset),
    .we     (wr_en),
    .idx    (count),
    .data   (cfg_data),
    .commit (pend_ok),
    .active (cfg_active)
  );

endmodule

// File: tb/tb_fabric_cfg_loader.sv
// Directed bench for fabric_cfg_loader with a commit-result scoreboard.
module tb_fabric_cfg_loader;

  localparam int CB = 891;
  localparam int W  = 112;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_abort = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [7:0]    cfg_data = '0;
  logic          cfg_ready;
  logic          cfg_busy;
  logic          cfg_done;
  logic          cfg_error;
  logic [CW-1:0] cfg_count;
  logic          fabric_en;
  logic [CB-1:0] cfg_active;

  typedef struct {
    logic          done;
    logic          err;
    logic          fen;
    logic [CB-1:0] act;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [7:0]    wds[W];
  logic [CB-1:0] cur_act = '0;
  logic          cur_fen = 1'b0;

  fabric_cfg_loader #(
    .CFG_BITS (CB),
    .DW       (8),
    .CHECK_EN (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_start  (cfg_start),
    .cfg_abort  (cfg_abort),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done),
    .cfg_error  (cfg_error),
    .cfg_count  (cfg_count),
    .fabric_en  (fabric_en),
    .cfg_active (cfg_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_act(input string tag, input logic [CB-1:0] exp);
    n_cmp++;
    assert (cfg_active === exp) else begin
      n_bad++;
      $error("FAIL %s: got lo128 %0h want lo128 %0h (hi3 %0h/%0h)",
             tag, cfg_active[127:0], exp[127:0],
             cfg_active[CB-1:CB-3], exp[CB-1:CB-3]);
    end
  endtask

  function automatic logic [CB-1:0] img_of();
    logic [W*8-1:0] t;
    t = '0;
    for (int k = 0; k < W; k++)
      t[k*8 +: 8] = wds[k];
    return t[CB-1:0];
  endfunction

  function automatic logic [7:0] sum_of();
    logic [7:0] s;
    s = '0;
    for (int k = 0; k < W; k++)
      s = s + wds[k];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: idle cycle before each word, 2: random stalls
  task automatic send_words(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      if (mode == 1) begin
        cfg_valid = 1'b0;
        cfg_data  = 8'($urandom);
        tick();
      end
      if (mode == 2) begin
        repeat ($urandom_range(0, 3)) begin
          cfg_valid = 1'b0;
          cfg_data  = 8'($urandom);
          tick();
        end
      end
      cfg_valid = 1'b1;
      cfg_data  = wds[k];
      tick();
      cfg_valid = 1'b0;
    end
  endtask

  task automatic finish_frame(input logic [7:0] ck, input string tag);
    exp_t e;
    logic ok;
    ok     = (ck == sum_of());
    e.done = ok;
    e.err  = !ok;
    if (ok) begin
      cur_act = img_of();
      cur_fen = 1'b1;
    end
    e.fen = cur_fen;
    e.act = cur_act;
    sb.push_back(e);
    chk({tag, ".cnt"}, 64'(cfg_count), 64'(W));
    cfg_valid = 1'b1;
    cfg_data  = ck;
    tick();
    cfg_valid = 1'b0;
    chk({tag, ".lat"}, 64'(cfg_done), 0);
    chk({tag, ".idle"}, 64'(cfg_busy), 0);
    tick();
    e = sb.pop_front();
    chk({tag, ".done"}, 64'(cfg_done), 64'(e.done));
    chk({tag, ".err"}, 64'(cfg_error), 64'(e.err));
    chk({tag, ".fen"}, 64'(fabric_en), 64'(e.fen));
    chk_act({tag, ".act"}, e.act);
    tick();
    chk({tag, ".pulse"}, 64'(cfg_done), 0);
  endtask

  initial begin
    // reset held with random inputs
    reset = 1'b0;
    repeat (4) begin
      cfg_start = 1'($urandom);
      cfg_abort = 1'($urandom);
      cfg_valid = 1'($urandom);
      cfg_data  = 8'($urandom);
      tick();
      chk("rst.ready", 64'(cfg_ready), 0);
      chk("rst.busy", 64'(cfg_busy), 0);
    end
    chk("rst.done", 64'(cfg_done), 0);
    chk("rst.err", 64'(cfg_error), 0);
    chk("rst.cnt", 64'(cfg_count), 0);
    chk("rst.fen", 64'(fabric_en), 0);
    chk_act("rst.act", '0);
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    chk("idle.ready", 64'(cfg_ready), 0);
    chk("idle.busy", 64'(cfg_busy), 0);

    // good frame
    for (int k = 0; k < W; k++)
      wds[k] = 8'(k);
    pulse_start();
    chk("g.ready", 64'(cfg_ready), 1);
    chk("g.busy", 64'(cfg_busy), 1);
    chk("g.cnt0", 64'(cfg_count), 0);
    send_words(W, 0);
    finish_frame(8'h48, "good");
    chk("g.b0", 64'(cfg_active[7:0]), 64'h00);
    chk("g.b1", 64'(cfg_active[15:8]), 64'h01);
    chk("g.top", 64'(cfg_active[890:888]), 64'h7);

    // bad checksum
    pulse_start();
    send_words(W, 0);
    finish_frame(8'h49, "bad");
    tick();
    chk("bad.sticky", 64'(cfg_error), 1);

    // words offered in IDLE are not taken
    cfg_valid = 1'b1;
    cfg_data  = 8'h5a;
    repeat (3) tick();
    chk("idle.rdy", 64'(cfg_ready), 0);
    chk("idle.cnt", 64'(cfg_count), 64'(W));
    cfg_valid = 1'b0;

    // gaps and stalls
    pulse_start();
    chk("gap.errclr", 64'(cfg_error), 0);
    send_words(W, 1);
    finish_frame(8'h48, "toggle");
    pulse_start();
    send_words(W, 2);
    finish_frame(8'h48, "stall");

    // abort after 50 words
    pulse_start();
    send_words(50, 0);
    chk("ab.cnt", 64'(cfg_count), 50);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("ab.busy", 64'(cfg_busy), 0);
    chk("ab.done", 64'(cfg_done), 0);
    chk("ab.err", 64'(cfg_error), 0);
    tick();
    chk("ab.done2", 64'(cfg_done), 0);
    chk_act("ab.act", cur_act);

    // restart at word 60, with a word offered on the start cycle
    pulse_start();
    send_words(60, 0);
    chk("rs.cnt60", 64'(cfg_count), 60);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 8'hff;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    chk("rs.cnt0", 64'(cfg_count), 0);
    chk("rs.busy", 64'(cfg_busy), 1);
    for (int k = 0; k < W; k++)
      wds[k] = 8'(k * 3 + 7);
    send_words(W, 0);
    finish_frame(sum_of(), "rs");

    // reset mid-frame after a commit
    pulse_start();
    send_words(60, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_act("mr.act", '0);
    chk("mr.fen", 64'(fabric_en), 0);
    chk("mr.busy", 64'(cfg_busy), 0);
    chk("mr.cnt", 64'(cfg_count), 0);
    tick();
    reset = 1'b1;
    tick();
    cur_act = '0;
    cur_fen = 1'b0;
    for (int k = 0; k < W; k++)
      wds[k] = ~8'(k);
    pulse_start();
    send_words(W, 2);
    finish_frame(sum_of(), "post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
